// File: rtl/pong_engine.sv
// Frame-stepped Pong engine: paddle/ball physics, scoring and serve/point/game-over sequencing.
// Every output is a register; play advances on frame_tick, while start leaves GAME_OVER on any cycle.
module pong_engine #(
  parameter int COORD_W      = 11,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int P1_X         = 50,
  parameter int P2_X         = 590,
  parameter int PADDLE_HALF  = 8,
  parameter int BALL_R       = 4,
  parameter int PADDLE_DY    = 5,
  parameter int BALL_DX      = 4,
  parameter int BALL_DY      = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [1:0]         player1,
  input  logic [1:0]         player2,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] p1_y,
  output logic [COORD_W-1:0] p2_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         state,
  output logic               game_over
);

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    POINT     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int SW    = COORD_W + 1;
  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  typedef logic signed [SW-1:0] scoord_t;

  localparam scoord_t VX      = scoord_t'(BALL_DX);
  localparam scoord_t VY      = scoord_t'(BALL_DY);
  localparam scoord_t PDY     = scoord_t'(PADDLE_DY);
  localparam scoord_t X_MIN   = scoord_t'(BALL_R);
  localparam scoord_t X_MAX   = scoord_t'(SCREEN_W - 1 - BALL_R);
  localparam scoord_t Y_MIN   = scoord_t'(BALL_R);
  localparam scoord_t Y_MAX   = scoord_t'(SCREEN_H - 1 - BALL_R);
  localparam scoord_t HIT1_X  = scoord_t'(P1_X + BALL_R);
  localparam scoord_t HIT2_X  = scoord_t'(P2_X - BALL_R);
  localparam scoord_t REACH   = scoord_t'(PADDLE_HALF + BALL_R);
  localparam scoord_t PAD_MIN = scoord_t'(PADDLE_HALF);
  localparam scoord_t PAD_MAX = scoord_t'(SCREEN_H - 1 - PADDLE_HALF);

  localparam logic [COORD_W-1:0] MID_X      = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] MID_Y      = COORD_W'(SCREEN_H / 2);
  localparam logic [SCORE_W-1:0] WIN_U      = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_t             state_reg, state_next;
  logic [COORD_W-1:0] ball_x_reg, ball_x_next, ball_y_reg, ball_y_next;
  logic [COORD_W-1:0] p1_y_reg, p1_y_next, p2_y_reg, p2_y_next;
  logic [SCORE_W-1:0] score1_reg, score1_next, score2_reg, score2_next;
  logic [CNT_W-1:0]   serve_cnt_reg, serve_cnt_next;
  logic               dx_neg_reg, dx_neg_next, dy_neg_reg, dy_neg_next;
  logic               game_over_reg, game_over_next;

  scoord_t cur_x, cur_y, nx, ny, d1, d2, adj_x, adj_y;
  logic    hit1, hit2, miss_l, miss_r, adj_dx_neg, adj_dy_neg, win, serve_done;

  function automatic scoord_t widen(input logic [COORD_W-1:0] v);
    return $signed({1'b0, v});
  endfunction

  function automatic logic [COORD_W-1:0] narrow(input scoord_t v);
    return v[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] paddle_step(input logic [COORD_W-1:0] y,
                                                     input logic [1:0] ctl);
    scoord_t v;
    v = widen(y);
    if (ctl == 2'b01)      v = v - PDY;
    else if (ctl == 2'b10) v = v + PDY;
    if (v < PAD_MIN)       v = PAD_MIN;
    else if (v > PAD_MAX)  v = PAD_MAX;
    return narrow(v);
  endfunction

  // Ball physics for one frame; paddle hits take priority over misses on the same axis.
  always_comb begin
    cur_x = widen(ball_x_reg);
    cur_y = widen(ball_y_reg);
    nx    = cur_x + (dx_neg_reg ? -VX : VX);
    ny    = cur_y + (dy_neg_reg ? -VY : VY);
    d1    = cur_y - widen(p1_y_reg);
    d2    = cur_y - widen(p2_y_reg);

    hit1   = dx_neg_reg && (cur_x >= HIT1_X) && (nx <= HIT1_X) &&
             (((d1 < 0) ? -d1 : d1) <= REACH);
    hit2   = !dx_neg_reg && (cur_x <= HIT2_X) && (nx >= HIT2_X) &&
             (((d2 < 0) ? -d2 : d2) <= REACH);
    miss_l = !hit1 && (nx <= X_MIN);
    miss_r = !hit2 && (nx >= X_MAX);

    adj_y      = ny;
    adj_dy_neg = dy_neg_reg;
    if (ny <= Y_MIN) begin
      adj_y      = Y_MIN;
      adj_dy_neg = 1'b0;
    end else if (ny >= Y_MAX) begin
      adj_y      = Y_MAX;
      adj_dy_neg = 1'b1;
    end

    // On a miss, dx is left pointing at the player who lost, ready for the next serve.
    adj_x      = nx;
    adj_dx_neg = dx_neg_reg;
    if (hit1) begin
      adj_x      = HIT1_X;
      adj_dx_neg = 1'b0;
    end else if (hit2) begin
      adj_x      = HIT2_X;
      adj_dx_neg = 1'b1;
    end else if (miss_l) begin
      adj_x      = X_MIN;
      adj_dx_neg = 1'b1;
    end else if (miss_r) begin
      adj_x      = X_MAX;
      adj_dx_neg = 1'b0;
    end
  end

  assign win        = (score1_reg == WIN_U) || (score2_reg == WIN_U);
  assign serve_done = (serve_cnt_reg == SERVE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= SERVE;
      ball_x_reg    <= MID_X;
      ball_y_reg    <= MID_Y;
      p1_y_reg      <= MID_Y;
      p2_y_reg      <= MID_Y;
      score1_reg    <= '0;
      score2_reg    <= '0;
      serve_cnt_reg <= '0;
      dx_neg_reg    <= 1'b0;
      dy_neg_reg    <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ball_x_reg    <= ball_x_next;
      ball_y_reg    <= ball_y_next;
      p1_y_reg      <= p1_y_next;
      p2_y_reg      <= p2_y_next;
      score1_reg    <= score1_next;
      score2_reg    <= score2_next;
      serve_cnt_reg <= serve_cnt_next;
      dx_neg_reg    <= dx_neg_next;
      dy_neg_reg    <= dy_neg_next;
      game_over_reg <= game_over_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SERVE:     if (frame_tick && serve_done) state_next = PLAY;
      PLAY:      if (frame_tick && (miss_l || miss_r)) state_next = POINT;
      POINT:     if (frame_tick) state_next = win ? GAME_OVER : SERVE;
      GAME_OVER: if (start) state_next = SERVE;
      default:   state_next = SERVE;
    endcase
  end

  always_comb begin
    ball_x_next    = ball_x_reg;
    ball_y_next    = ball_y_reg;
    score1_next    = score1_reg;
    score2_next    = score2_reg;
    serve_cnt_next = serve_cnt_reg;
    dx_neg_next    = dx_neg_reg;
    dy_neg_next    = dy_neg_reg;
    p1_y_next      = frame_tick ? paddle_step(p1_y_reg, player1) : p1_y_reg;
    p2_y_next      = frame_tick ? paddle_step(p2_y_reg, player2) : p2_y_reg;
    game_over_next = (state_next == GAME_OVER);

    case (state_reg)
      SERVE: begin
        ball_x_next = MID_X;
        ball_y_next = MID_Y;
        dy_neg_next = 1'b0;
        if (frame_tick) serve_cnt_next = serve_done ? '0 : serve_cnt_reg + 1'b1;
      end
      PLAY: begin
        if (frame_tick) begin
          ball_x_next = narrow(adj_x);
          ball_y_next = narrow(adj_y);
          dx_neg_next = adj_dx_neg;
          dy_neg_next = adj_dy_neg;
          if (miss_l && score2_reg < WIN_U) score2_next = score2_reg + 1'b1;
          if (miss_r && score1_reg < WIN_U) score1_next = score1_reg + 1'b1;
        end
      end
      POINT: begin
        if (frame_tick) begin
          serve_cnt_next = '0;
          if (!win) begin
            ball_x_next = MID_X;
            ball_y_next = MID_Y;
            dy_neg_next = 1'b0;
          end
        end
      end
      GAME_OVER: begin
        if (start) begin
          score1_next    = '0;
          score2_next    = '0;
          serve_cnt_next = '0;
          ball_x_next    = MID_X;
          ball_y_next    = MID_Y;
          dx_neg_next    = 1'b0;
          dy_neg_next    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign ball_x    = ball_x_reg;
  assign ball_y    = ball_y_reg;
  assign p1_y      = p1_y_reg;
  assign p2_y      = p2_y_reg;
  assign score1    = score1_reg;
  assign score2    = score2_reg;
  assign state     = state_reg;
  assign game_over = game_over_reg;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: a scripted rally with hand-traced ball positions,
// paddle clamping, async reset and a full game to WIN_SCORE.
module tb_pong_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        start;
  logic [1:0]  player1;
  logic [1:0]  player2;
  logic [10:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0]  score1, score2;
  logic [1:0]  state;
  logic        game_over;

  int checks   = 0;
  int failures = 0;

  pong_engine dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .player1    (player1),
    .player2    (player2),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .score1     (score1),
    .score2     (score2),
    .state      (state),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Each call issues n frame ticks; returns on a falling edge with results visible.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0; player1 = 2'b00; player2 = 2'b00;
    do_reset();
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if ({ball_x, ball_y} !== {11'd320, 11'd240}) begin
      failures++; $display("FAIL reset_ball: got (%0d,%0d) want (320,240)", ball_x, ball_y);
    end
    checks++;
    if ({p1_y, p2_y} !== {11'd240, 11'd240}) begin
      failures++; $display("FAIL reset_paddles: got %0d/%0d want 240/240", p1_y, p2_y);
    end
    checks++;
    if ({score1, score2, game_over} !== 9'd0) begin
      failures++; $display("FAIL reset_scores: got %0d/%0d go=%0d want 0/0 go=0", score1, score2, game_over);
    end
    $display("test_reset: state=%0d ball=(%0d,%0d)", state, ball_x, ball_y);
  endtask

  // Frames 1..61: serve countdown while paddle 2 moves down to 370, then first play step.
  task automatic test_serve();
    player2 = 2'b10;
    tick(26);
    player2 = 2'b00;
    checks++;
    if (p2_y !== 11'd370) begin failures++; $display("FAIL paddle_down: got %0d want 370", p2_y); end
    tick(33);
    checks++;
    if (state !== 2'd0 || {ball_x, ball_y} !== {11'd320, 11'd240}) begin
      failures++; $display("FAIL serve_hold: state=%0d ball=(%0d,%0d) want 0 (320,240)", state, ball_x, ball_y);
    end
    tick(1);
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL serve_to_play: got %0d want 1", state); end
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd324, 11'd242}) begin
      failures++; $display("FAIL first_step: got (%0d,%0d) want (324,242)", ball_x, ball_y);
    end
    $display("test_serve: state=%0d ball=(%0d,%0d)", state, ball_x, ball_y);
  endtask

  task automatic test_start_ignored();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (state !== 2'd1 || {ball_x, ball_y} !== {11'd324, 11'd242}) begin
      failures++; $display("FAIL start_in_play: state=%0d ball=(%0d,%0d) want 1 (324,242)", state, ball_x, ball_y);
    end
    $display("test_start_ignored: state=%0d", state);
  endtask

  // Frames 62..128: paddle 1 to 310, ball meets paddle 2 at frame 127.
  task automatic test_paddle_hit_right();
    player1 = 2'b10;
    tick(14);
    player1 = 2'b00;
    checks++;
    if (p1_y !== 11'd310) begin failures++; $display("FAIL paddle1_move: got %0d want 310", p1_y); end
    tick(52);
    checks++;
    if ({ball_x, ball_y} !== {11'd586, 11'd374}) begin
      failures++; $display("FAIL hit_right: got (%0d,%0d) want (586,374)", ball_x, ball_y);
    end
    player2 = 2'b01;
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd582, 11'd376}) begin
      failures++; $display("FAIL after_hit_right: got (%0d,%0d) want (582,376)", ball_x, ball_y);
    end
    $display("test_paddle_hit_right: ball=(%0d,%0d)", ball_x, ball_y);
  endtask

  // Frames 129..192: bottom wall bounce at 178 while paddle 2 climbs to 45.
  task automatic test_wall_bottom();
    tick(49);
    checks++;
    if ({ball_x, ball_y} !== {11'd386, 11'd474}) begin
      failures++; $display("FAIL pre_bottom: got (%0d,%0d) want (386,474)", ball_x, ball_y);
    end
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd382, 11'd475}) begin
      failures++; $display("FAIL bottom_clamp: got (%0d,%0d) want (382,475)", ball_x, ball_y);
    end
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd378, 11'd473}) begin
      failures++; $display("FAIL bottom_reflect: got (%0d,%0d) want (378,473)", ball_x, ball_y);
    end
    tick(13);
    player2 = 2'b00;
    checks++;
    if (p2_y !== 11'd45) begin failures++; $display("FAIL paddle2_up: got %0d want 45", p2_y); end
    $display("test_wall_bottom: ball=(%0d,%0d) p2=%0d", ball_x, ball_y, p2_y);
  endtask

  // Frames 193..261: ball meets paddle 1 (y=310) at frame 260.
  task automatic test_paddle_hit_left();
    tick(67);
    checks++;
    if ({ball_x, ball_y} !== {11'd58, 11'd313}) begin
      failures++; $display("FAIL pre_hit_left: got (%0d,%0d) want (58,313)", ball_x, ball_y);
    end
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd54, 11'd311}) begin
      failures++; $display("FAIL hit_left: got (%0d,%0d) want (54,311)", ball_x, ball_y);
    end
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd58, 11'd309}) begin
      failures++; $display("FAIL after_hit_left: got (%0d,%0d) want (58,309)", ball_x, ball_y);
    end
    $display("test_paddle_hit_left: ball=(%0d,%0d)", ball_x, ball_y);
  endtask

  // Frames 262..415: second paddle-2 hit at 393, top wall clamp from y=5 at 414.
  task automatic test_wall_top();
    tick(132);
    checks++;
    if ({ball_x, ball_y} !== {11'd586, 11'd45}) begin
      failures++; $display("FAIL hit_right_high: got (%0d,%0d) want (586,45)", ball_x, ball_y);
    end
    tick(20);
    checks++;
    if ({ball_x, ball_y} !== {11'd506, 11'd5}) begin
      failures++; $display("FAIL pre_top: got (%0d,%0d) want (506,5)", ball_x, ball_y);
    end
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd502, 11'd4}) begin
      failures++; $display("FAIL top_clamp: got (%0d,%0d) want (502,4)", ball_x, ball_y);
    end
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd498, 11'd6}) begin
      failures++; $display("FAIL top_reflect: got (%0d,%0d) want (498,6)", ball_x, ball_y);
    end
    $display("test_wall_top: ball=(%0d,%0d)", ball_x, ball_y);
  endtask

  // Frames 416..540: paddle 1 is far away, ball exits left, player 2 scores.
  task automatic test_miss_left();
    tick(123);
    checks++;
    if ({ball_x, ball_y} !== {11'd6, 11'd252} || state !== 2'd1 || score2 !== 4'd0) begin
      failures++; $display("FAIL pre_miss: ball=(%0d,%0d) state=%0d s2=%0d want (6,252) 1 0", ball_x, ball_y, state, score2);
    end
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd4, 11'd254}) begin
      failures++; $display("FAIL miss_freeze: got (%0d,%0d) want (4,254)", ball_x, ball_y);
    end
    checks++;
    if (state !== 2'd2 || score2 !== 4'd1 || score1 !== 4'd0) begin
      failures++; $display("FAIL miss_point: state=%0d s1=%0d s2=%0d want 2 0 1", state, score1, score2);
    end
    tick(1);
    checks++;
    if (state !== 2'd0 || {ball_x, ball_y} !== {11'd320, 11'd240}) begin
      failures++; $display("FAIL point_to_serve: state=%0d ball=(%0d,%0d) want 0 (320,240)", state, ball_x, ball_y);
    end
    $display("test_miss_left: score1=%0d score2=%0d", score1, score2);
  endtask

  task automatic test_serve_direction();
    tick(60);
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL reserve_play: got %0d want 1", state); end
    tick(1);
    checks++;
    if ({ball_x, ball_y} !== {11'd316, 11'd242}) begin
      failures++; $display("FAIL serve_toward_loser: got (%0d,%0d) want (316,242)", ball_x, ball_y);
    end
    $display("test_serve_direction: ball=(%0d,%0d)", ball_x, ball_y);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || {ball_x, ball_y} !== {11'd320, 11'd240}) begin
      failures++; $display("FAIL async_ball: state=%0d ball=(%0d,%0d) want 0 (320,240)", state, ball_x, ball_y);
    end
    checks++;
    if ({p1_y, p2_y} !== {11'd240, 11'd240} || {score1, score2, game_over} !== 9'd0) begin
      failures++; $display("FAIL async_rest: p=%0d/%0d s=%0d/%0d go=%0d want 240/240 0/0 0", p1_y, p2_y, score1, score2, game_over);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("test_async_reset: state=%0d", state);
  endtask

  task automatic test_paddle_clamp();
    player1 = 2'b01;
    player2 = 2'b10;
    tick(50);
    checks++;
    if ({p1_y, p2_y} !== {11'd8, 11'd471}) begin
      failures++; $display("FAIL paddle_clamp: got %0d/%0d want 8/471", p1_y, p2_y);
    end
    player1 = 2'b11;
    player2 = 2'b11;
    tick(1);
    checks++;
    if ({p1_y, p2_y} !== {11'd8, 11'd471}) begin
      failures++; $display("FAIL paddle_hold: got %0d/%0d want 8/471", p1_y, p2_y);
    end
    player1 = 2'b00;
    player2 = 2'b00;
    $display("test_paddle_clamp: p1=%0d p2=%0d", p1_y, p2_y);
  endtask

  // Player 1 wins seven identical rallies: 60 serve + 79 play + 1 point frames each.
  task automatic test_game_over();
    logic [1:0] exp_st;
    logic       exp_go;
    do_reset();
    for (int r = 1; r <= 7; r++) begin
      tick(139);
      checks++;
      if (state !== 2'd2 || score1 !== 4'(r) || {ball_x, ball_y} !== {11'd635, 11'd398}) begin
        failures++; $display("FAIL round%0d_point: state=%0d s1=%0d ball=(%0d,%0d) want 2 %0d (635,398)", r, state, score1, ball_x, ball_y, r);
      end
      exp_st = (r == 7) ? 2'd3 : 2'd0;
      exp_go = (r == 7);
      tick(1);
      checks++;
      if (state !== exp_st || game_over !== exp_go) begin
        failures++; $display("FAIL round%0d_after: state=%0d go=%0d want %0d %0d", r, state, game_over, exp_st, exp_go);
      end
      $display("test_game_over: round %0d score1=%0d state=%0d", r, score1, state);
    end
    player1 = 2'b10;
    tick(1);
    player1 = 2'b00;
    checks++;
    if (p1_y !== 11'd245 || {ball_x, ball_y} !== {11'd635, 11'd398} || score1 !== 4'd7 || state !== 2'd3) begin
      failures++; $display("FAIL game_over_freeze: p1=%0d ball=(%0d,%0d) s1=%0d state=%0d want 245 (635,398) 7 3", p1_y, ball_x, ball_y, score1, state);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (state !== 2'd0 || {score1, score2, game_over} !== 9'd0 || {ball_x, ball_y} !== {11'd320, 11'd240}) begin
      failures++; $display("FAIL start_restart: state=%0d s=%0d/%0d go=%0d ball=(%0d,%0d) want 0 0/0 0 (320,240)", state, score1, score2, game_over, ball_x, ball_y);
    end
    tick(61);
    checks++;
    if ({ball_x, ball_y} !== {11'd324, 11'd242}) begin
      failures++; $display("FAIL restart_serve_dir: got (%0d,%0d) want (324,242)", ball_x, ball_y);
    end
    $display("test_game_over: restarted ball=(%0d,%0d)", ball_x, ball_y);
  endtask

  initial begin
    test_reset();
    test_serve();
    test_start_ignored();
    test_paddle_hit_right();
    test_wall_bottom();
    test_paddle_hit_left();
    test_wall_top();
    test_miss_left();
    test_serve_direction();
    test_async_reset();
    test_paddle_clamp();
    test_game_over();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
